// File: rtl/sdrc_cmd_monitor.sv
// sdrc_cmd_monitor: passive SDRAM command-bus monitor with per-bank tRCD/tRP tracking,
// saturating command counters and first-violation latching. Optional macro: SDRC_ROW_TRACK_EN.
`default_nettype none

module sdrc_cmd_monitor #(
   parameter int NUM_BANKS = 4,
   parameter int ROW_W     = 13,
   parameter int CNT_W     = 16,
   parameter int TRCD      = 3,
   parameter int TRP       = 3,
   localparam int BA_W     = $clog2(NUM_BANKS)
) (
   input  logic                       sdram_clk,
   input  logic                       sdram_resetn,
   input  logic                       sdr_cs_n,
   input  logic                       sdr_ras_n,
   input  logic                       sdr_cas_n,
   input  logic                       sdr_we_n,
   input  logic [BA_W-1:0]            sdr_ba,
   input  logic [ROW_W-1:0]           sdr_addr,
   input  logic                       clr,
   output logic                       cmd_vld,
   output logic [2:0]                 cmd_code,
   output logic [NUM_BANKS-1:0]       bank_open,
   output logic                       err_flag,
   output logic [2:0]                 err_code,
   output logic [CNT_W-1:0]           act_cnt,
   output logic [CNT_W-1:0]           rd_cnt,
   output logic [CNT_W-1:0]           wr_cnt,
   output logic [CNT_W-1:0]           ref_cnt,
   output logic [NUM_BANKS*ROW_W-1:0] open_row
);

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_ACT = 3'd1;
   localparam logic [2:0] CMD_RD  = 3'd2;
   localparam logic [2:0] CMD_WR  = 3'd3;
   localparam logic [2:0] CMD_PRE = 3'd4;
   localparam logic [2:0] CMD_REF = 3'd5;
   localparam logic [2:0] CMD_MRS = 3'd6;
   localparam logic [2:0] CMD_BST = 3'd7;

   typedef enum logic [1:0] {IDLE, ACTING, ACTIVE, PRECHG} bank_state_t;

   logic [2:0]  cmd_now;
   bank_state_t state_q [NUM_BANKS];
   bank_state_t state_d [NUM_BANKS];
   logic [3:0]  timer_q [NUM_BANKS];
   logic [3:0]  timer_d [NUM_BANKS];
   bank_state_t sel_state;
   logic        any_busy;
   logic [2:0]  viol;

   always_comb begin
      cmd_now = CMD_NOP;
      if (!sdr_cs_n) begin
         case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
            3'b011:  cmd_now = CMD_ACT;
            3'b101:  cmd_now = CMD_RD;
            3'b100:  cmd_now = CMD_WR;
            3'b010:  cmd_now = CMD_PRE;
            3'b001:  cmd_now = CMD_REF;
            3'b000:  cmd_now = CMD_MRS;
            3'b110:  cmd_now = CMD_BST;
            default: cmd_now = CMD_NOP;
         endcase
      end
   end

   // Timers count down to the state change; a command in the same cycle overrides it.
   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         state_d[b] = state_q[b];
         timer_d[b] = timer_q[b];
         case (state_q[b])
            ACTING: begin
               if (timer_q[b] <= 4'd1) begin
                  state_d[b] = ACTIVE;
                  timer_d[b] = 4'd0;
               end else begin
                  timer_d[b] = timer_q[b] - 4'd1;
               end
            end
            PRECHG: begin
               if (timer_q[b] <= 4'd1) begin
                  state_d[b] = IDLE;
                  timer_d[b] = 4'd0;
               end else begin
                  timer_d[b] = timer_q[b] - 4'd1;
               end
            end
            default: ;
         endcase
         if (cmd_now == CMD_ACT && sdr_ba == BA_W'(b)) begin
            state_d[b] = (TRCD == 1) ? ACTIVE : ACTING;
            timer_d[b] = (TRCD == 1) ? 4'd0 : 4'(TRCD - 1);
         end else if (cmd_now == CMD_PRE && (sdr_ba == BA_W'(b) || sdr_addr[10]) &&
                      (state_q[b] == ACTING || state_q[b] == ACTIVE)) begin
            state_d[b] = (TRP == 1) ? IDLE : PRECHG;
            timer_d[b] = (TRP == 1) ? 4'd0 : 4'(TRP - 1);
         end
      end
   end

   always_comb begin
      any_busy = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (state_q[b] != IDLE) any_busy = 1'b1;
      end
      sel_state = state_q[sdr_ba];
      viol      = 3'd0;
      case (cmd_now)
         CMD_RD, CMD_WR: begin
            if (sel_state == IDLE || sel_state == PRECHG) viol = 3'd1;
            else if (sel_state == ACTING)                 viol = 3'd2;
         end
         CMD_ACT: begin
            if (sel_state == ACTING || sel_state == ACTIVE) viol = 3'd3;
            else if (sel_state == PRECHG)                   viol = 3'd4;
         end
         CMD_REF, CMD_MRS: begin
            if (any_busy) viol = 3'd5;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= IDLE;
            timer_q[b] <= 4'd0;
         end
         cmd_vld  <= 1'b0;
         cmd_code <= CMD_NOP;
         err_flag <= 1'b0;
         err_code <= 3'd0;
         act_cnt  <= '0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         ref_cnt  <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            state_q[b] <= state_d[b];
            timer_q[b] <= timer_d[b];
         end
         cmd_vld  <= (cmd_now != CMD_NOP);
         cmd_code <= cmd_now;
         if (clr) begin
            err_flag <= 1'b0;
            err_code <= 3'd0;
            act_cnt  <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            ref_cnt  <= '0;
         end else begin
            if (cmd_now == CMD_ACT && act_cnt != '1) act_cnt <= act_cnt + CNT_W'(1);
            if (cmd_now == CMD_RD  && rd_cnt  != '1) rd_cnt  <= rd_cnt  + CNT_W'(1);
            if (cmd_now == CMD_WR  && wr_cnt  != '1) wr_cnt  <= wr_cnt  + CNT_W'(1);
            if (cmd_now == CMD_REF && ref_cnt != '1) ref_cnt <= ref_cnt + CNT_W'(1);
            if (viol != 3'd0 && !err_flag) begin
               err_flag <= 1'b1;
               err_code <= viol;
            end
         end
      end
   end

   always_comb begin
      bank_open = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_open[b] = (state_q[b] == ACTIVE);
      end
   end

`ifdef SDRC_ROW_TRACK_EN
   logic [ROW_W-1:0] row_q [NUM_BANKS];

   always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
      if (!sdram_resetn) begin
         for (int b = 0; b < NUM_BANKS; b++) row_q[b] <= '0;
      end else if (cmd_now == CMD_ACT) begin
         row_q[sdr_ba] <= sdr_addr;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_row
      assign open_row[b*ROW_W +: ROW_W] = bank_open[b] ? row_q[b] : '0;
   end
`else
   logic unused_addr;
   assign unused_addr = ^sdr_addr;
   assign open_row    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdrc_cmd_monitor.sv
// Self-checking bench for sdrc_cmd_monitor: directed scenarios plus randomized traffic
// compared against a cycle-stamp bank model.
`default_nettype none

module tb_sdrc_cmd_monitor;
   localparam int NB   = 8;
   localparam int BW   = 3;
   localparam int RW   = 13;
   localparam int CW   = 4;
   localparam int TRCD = 3;
   localparam int TRP  = 3;
   localparam int MAXC = (1 << CW) - 1;

   localparam logic [3:0] C_NOP = 4'b0111;
   localparam logic [3:0] C_ACT = 4'b0011;
   localparam logic [3:0] C_RD  = 4'b0101;
   localparam logic [3:0] C_WR  = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010;
   localparam logic [3:0] C_REF = 4'b0001;
   localparam logic [3:0] C_MRS = 4'b0000;
   localparam logic [3:0] C_BST = 4'b0110;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, clr = 1'b0;
   logic [BW-1:0] ba = '0;
   logic [RW-1:0] addr = '0;
   logic          cmd_vld;
   logic [2:0]    cmd_code;
   logic [NB-1:0] bank_open;
   logic          err_flag;
   logic [2:0]    err_code;
   logic [CW-1:0] act_cnt, rd_cnt, wr_cnt, ref_cnt;
   logic [NB*RW-1:0] open_row;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sdrc_cmd_monitor #(.NUM_BANKS(NB), .ROW_W(RW), .CNT_W(CW), .TRCD(TRCD), .TRP(TRP)) dut (
      .sdram_clk(clk), .sdram_resetn(resetn),
      .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
      .sdr_ba(ba), .sdr_addr(addr), .clr(clr),
      .cmd_vld(cmd_vld), .cmd_code(cmd_code), .bank_open(bank_open),
      .err_flag(err_flag), .err_code(err_code),
      .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .ref_cnt(ref_cnt),
      .open_row(open_row)
   );

   // Reference model: each bank remembers whether it is open and the cycle of its last ACT/PRE.
   int          cyc;
   bit          m_open [NB];
   int          m_act  [NB];
   int          m_pre  [NB];
   logic [RW-1:0] m_row [NB];
   bit          m_err;
   int          m_code;
   int          m_cnt  [4];
   int          m_cmd;

   function automatic int decode(logic [3:0] c);
      if (c[3]) return 0;
      case (c[2:0])
         3'b011:  return 1;
         3'b101:  return 2;
         3'b100:  return 3;
         3'b010:  return 4;
         3'b001:  return 5;
         3'b000:  return 6;
         3'b110:  return 7;
         default: return 0;
      endcase
   endfunction

   // 0 idle, 1 waiting tRCD, 2 active, 3 waiting tRP -- as seen during cycle x
   function automatic int bstate(int b, int x);
      if (m_open[b]) return (x - m_act[b] >= TRCD) ? 2 : 1;
      return (x - m_pre[b] < TRP) ? 3 : 0;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NB; i++) begin
         m_open[i] = 0; m_act[i] = -1000; m_pre[i] = -1000; m_row[i] = '0;
      end
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_err = 0; m_code = 0; m_cmd = 0;
   endfunction

   function automatic void model_sample(logic [3:0] c, int b, logic [RW-1:0] a, bit cl);
      int  code = decode(c);
      int  s    = bstate(b, cyc);
      int  v    = 0;
      bit  busy = 0;
      for (int i = 0; i < NB; i++) if (bstate(i, cyc) != 0) busy = 1;
      case (code)
         1: begin
            if (s == 1 || s == 2) v = 3; else if (s == 3) v = 4;
            m_open[b] = 1; m_act[b] = cyc; m_row[b] = a;
         end
         2, 3: begin
            if (s == 0 || s == 3) v = 1; else if (s == 1) v = 2;
         end
         4: for (int i = 0; i < NB; i++) begin
            if ((i == b || a[10]) && m_open[i]) begin m_open[i] = 0; m_pre[i] = cyc; end
         end
         5, 6: if (busy) v = 5;
         default: ;
      endcase
      if (cl) begin
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_err = 0; m_code = 0;
      end else begin
         if (code == 1 && m_cnt[0] < MAXC) m_cnt[0]++;
         if (code == 2 && m_cnt[1] < MAXC) m_cnt[1]++;
         if (code == 3 && m_cnt[2] < MAXC) m_cnt[2]++;
         if (code == 5 && m_cnt[3] < MAXC) m_cnt[3]++;
         if (v != 0 && !m_err) begin m_err = 1; m_code = v; end
      end
      m_cmd = code;
   endfunction

   function automatic logic [NB-1:0] exp_open();
      logic [NB-1:0] r = '0;
      for (int i = 0; i < NB; i++) r[i] = (bstate(i, cyc) == 2);
      return r;
   endfunction

   function automatic logic [NB*RW-1:0] exp_row();
      logic [NB*RW-1:0] r = '0;
`ifdef SDRC_ROW_TRACK_EN
      for (int i = 0; i < NB; i++) if (bstate(i, cyc) == 2) r[i*RW +: RW] = m_row[i];
`endif
      return r;
   endfunction

   // One bus cycle: drive, sample edge, advance model, settle 1 time unit past the edge.
   task automatic drive(input logic [3:0] c, input int b, input int a, input bit cl);
      {cs_n, ras_n, cas_n, we_n} = c;
      ba = BW'(b); addr = RW'(a); clr = cl;
      @(posedge clk);
      model_sample(c, b, RW'(a), cl);
      cyc++;
      #1;
   endtask

   task automatic idle_all();
      drive(C_PRE, 0, 13'h0400, 1'b0);
      repeat (3) drive(C_NOP, 0, 0, 1'b0);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      {cs_n, ras_n, cas_n, we_n} = C_ACT;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_vld !== 1'b0 || cmd_code !== 3'd0) begin errors++; $display("FAIL reset_cmd: got vld=%0b code=%0d required 0/0", cmd_vld, cmd_code); end
      checks++; if (bank_open !== '0) begin errors++; $display("FAIL reset_bank_open: got %0h required 0", bank_open); end
      checks++; if (err_flag !== 1'b0 || err_code !== 3'd0) begin errors++; $display("FAIL reset_err: got %0b/%0d required 0/0", err_flag, err_code); end
      checks++; if ({act_cnt, rd_cnt, wr_cnt, ref_cnt} !== '0 || open_row !== '0) begin errors++; $display("FAIL reset_counters: got %0h row=%0h required 0", {act_cnt, rd_cnt, wr_cnt, ref_cnt}, open_row); end
      {cs_n, ras_n, cas_n, we_n} = C_NOP;
      #2 resetn = 1'b1;
      model_reset();
      cyc = 0;
   endtask

   task automatic test_act_rd();
      drive(C_NOP, 0, 0, 1'b1);
      drive(C_ACT, 1, 13'h155, 1'b0);
      checks++; if (cmd_vld !== 1'b1 || cmd_code !== 3'd1) begin errors++; $display("FAIL act_decode: got vld=%0b code=%0d required 1/1", cmd_vld, cmd_code); end
      drive(C_NOP, 0, 0, 1'b0);
      checks++; if (bank_open !== 8'h00) begin errors++; $display("FAIL trcd_not_open: got %0h required 00", bank_open); end
      drive(C_NOP, 0, 0, 1'b0);
      checks++; if (bank_open !== 8'h02) begin errors++; $display("FAIL trcd_open: got %0h required 02", bank_open); end
      drive(C_RD, 1, 0, 1'b0);
      checks++; if (rd_cnt !== 4'd1 || err_flag !== 1'b0) begin errors++; $display("FAIL legal_rd: got rd_cnt=%0d err=%0b required 1/0", rd_cnt, err_flag); end
`ifdef SDRC_ROW_TRACK_EN
      checks++; if (open_row[25:13] !== 13'h155) begin errors++; $display("FAIL open_row: got %0h required 155", open_row[25:13]); end
`else
      checks++; if (open_row !== '0) begin errors++; $display("FAIL open_row_tied: got %0h required 0", open_row); end
`endif
      idle_all();
   endtask

   task automatic test_trcd_violation();
      drive(C_NOP, 0, 0, 1'b1);
      drive(C_ACT, 2, 13'h0aa, 1'b0);
      checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL trcd_pre_err: got %0b required 0", err_flag); end
      drive(C_RD, 2, 0, 1'b0);
      checks++; if (err_flag !== 1'b1 || err_code !== 3'd2) begin errors++; $display("FAIL trcd_err: got %0b/%0d required 1/2", err_flag, err_code); end
      checks++; if (rd_cnt !== 4'd1) begin errors++; $display("FAIL trcd_rd_cnt: got %0d required 1", rd_cnt); end
   endtask

   task automatic test_trp_violation();
      drive(C_NOP, 0, 0, 1'b1);
      drive(C_ACT, 0, 13'h011, 1'b0);
      drive(C_ACT, 1, 13'h022, 1'b0);
      repeat (3) drive(C_NOP, 0, 0, 1'b0);
      checks++; if (bank_open !== 8'h07) begin errors++; $display("FAIL two_open: got %0h required 07", bank_open); end
      drive(C_PRE, 5, 13'h0400, 1'b0);
      checks++; if (bank_open !== 8'h00) begin errors++; $display("FAIL prechg_closed: got %0h required 00", bank_open); end
      drive(C_ACT, 0, 13'h033, 1'b0);
      checks++; if (err_flag !== 1'b1 || err_code !== 3'd4) begin errors++; $display("FAIL trp_err: got %0b/%0d required 1/4", err_flag, err_code); end
      idle_all();
   endtask

   task automatic test_ref_violation();
      drive(C_NOP, 0, 0, 1'b1);
      drive(C_ACT, 3, 13'h044, 1'b0);
      drive(C_REF, 0, 0, 1'b0);
      checks++; if (err_flag !== 1'b1 || err_code !== 3'd5) begin errors++; $display("FAIL ref_busy_err: got %0b/%0d required 1/5", err_flag, err_code); end
      drive(C_WR, 0, 0, 1'b0);
      checks++; if (err_code !== 3'd5 || wr_cnt !== 4'd1) begin errors++; $display("FAIL err_first_kept: got code=%0d wr=%0d required 5/1", err_code, wr_cnt); end
      idle_all();
   endtask

   task automatic test_saturation_clr();
      drive(C_NOP, 0, 0, 1'b1);
      repeat (20) drive(C_REF, 0, 0, 1'b0);
      checks++; if (ref_cnt !== 4'd15 || err_flag !== 1'b0) begin errors++; $display("FAIL ref_saturate: got %0d err=%0b required 15/0", ref_cnt, err_flag); end
      drive(C_ACT, 0, 13'h055, 1'b0);
      drive(C_REF, 0, 0, 1'b1);
      checks++; if (ref_cnt !== 4'd0 || err_flag !== 1'b0 || act_cnt !== 4'd0) begin errors++; $display("FAIL clr_wins: got ref=%0d err=%0b act=%0d required 0/0/0", ref_cnt, err_flag, act_cnt); end
      idle_all();
   endtask

   task automatic test_reset_midop();
      drive(C_ACT, 7, 13'h066, 1'b0);
      drive(C_ACT, 7, 13'h067, 1'b0);
      #1 resetn = 1'b0;
      #1;
      checks++; if (cmd_vld !== 1'b0 || cmd_code !== 3'd0 || act_cnt !== 4'd0) begin errors++; $display("FAIL async_reset_cmd: got vld=%0b code=%0d act=%0d required 0", cmd_vld, cmd_code, act_cnt); end
      checks++; if (err_flag !== 1'b0 || err_code !== 3'd0 || bank_open !== '0) begin errors++; $display("FAIL async_reset_err: got %0b/%0d open=%0h required 0", err_flag, err_code, bank_open); end
      model_reset();
      #1 resetn = 1'b1;
      drive(C_NOP, 0, 0, 1'b0);
      drive(C_RD, 7, 0, 1'b0);
      checks++; if (err_flag !== 1'b1 || err_code !== 3'd1) begin errors++; $display("FAIL rd_after_reset: got %0b/%0d required 1/1", err_flag, err_code); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] c;
      int k, a;
      for (int i = 0; i < 400; i++) begin
         k = $urandom_range(0, 11);
         case (k)
            0, 1:    c = C_ACT;
            2:       c = C_RD;
            3:       c = C_WR;
            4, 5:    c = C_PRE;
            6:       c = C_REF;
            7:       c = C_MRS;
            8:       c = C_BST;
            9, 10:   c = C_NOP;
            default: c = {1'b1, 3'($urandom)};
         endcase
         a = $urandom_range(0, 8191);
         if ($urandom_range(0, 3) != 0) a = a & ~(1 << 10);
         drive(c, $urandom_range(0, NB - 1), a, ($urandom_range(0, 29) == 0));
         checks++; if (cmd_vld !== (m_cmd != 0)) begin errors++; $display("FAIL rnd_vld @%0d: got %0b required %0b", cyc, cmd_vld, (m_cmd != 0)); end
         checks++; if (cmd_code !== 3'(m_cmd)) begin errors++; $display("FAIL rnd_code @%0d: got %0d required %0d", cyc, cmd_code, m_cmd); end
         checks++; if (bank_open !== exp_open()) begin errors++; $display("FAIL rnd_bank_open @%0d: got %0h required %0h", cyc, bank_open, exp_open()); end
         checks++; if (err_flag !== m_err) begin errors++; $display("FAIL rnd_err_flag @%0d: got %0b required %0b", cyc, err_flag, m_err); end
         checks++; if (err_code !== 3'(m_code)) begin errors++; $display("FAIL rnd_err_code @%0d: got %0d required %0d", cyc, err_code, m_code); end
         checks++; if ({act_cnt, rd_cnt, wr_cnt, ref_cnt} !== {CW'(m_cnt[0]), CW'(m_cnt[1]), CW'(m_cnt[2]), CW'(m_cnt[3])}) begin
            errors++; $display("FAIL rnd_counters @%0d: got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d", cyc, act_cnt, rd_cnt, wr_cnt, ref_cnt, m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
         end
         checks++; if (open_row !== exp_row()) begin errors++; $display("FAIL rnd_open_row @%0d: got %0h required %0h", cyc, open_row, exp_row()); end
      end
   endtask

   initial begin
      test_reset();
      test_act_rd();
      test_trcd_violation();
      test_trp_violation();
      test_ref_violation();
      test_saturation_clr();
      test_reset_midop();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
